// File: rtl/lsu.sv
// Load/store unit between the execute stage and the data-memory bus.
// Runs one req/gnt/rvalid transaction per load or store and stalls the core
// meanwhile. Load data comes back sign- or zero-extended. Misaligned accesses and
// illegal funct3 codes are reported through done/misalign without touching the bus.
//
// Ports:
//   clk_i, rst_ni          clock; synchronous active-low reset
//   load_i, store_i        access request (load wins if both high), held while stall_o
//   funct3_i, addr_i       width/sign code and effective address
//   wdata_i                store data
//   stall_o                core must hold this cycle
//   done_o, misalign_o     retire pulse and error qualifier
//   ldata_o                extended load data, held until the next load retires
//   mem_*_o / mem_*_i      data-memory bus (req/gnt, rvalid/rdata)
module lsu #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              misalign_o,
  output logic [31:0]       ldata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              err_q;
  logic              done_q;
  logic [31:0]       ldata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;

  logic [1:0]  off;
  logic        req_err;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] ext;

  assign off = addr_i[1:0];

  // Legality of the incoming access; funct3[1:0] encodes the size.
  always_comb begin
    req_err = 1'b0;
    if (load_i) begin
      if (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11) req_err = 1'b1;
    end else begin
      if (funct3_i >= 3'b011) req_err = 1'b1;
    end
    if (funct3_i[1:0] == 2'b01 && off[0]) req_err = 1'b1;
    if (funct3_i[1:0] == 2'b10 && off != 2'b00) req_err = 1'b1;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << off;
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
      end
    endcase
  end

  // Pick the addressed lane(s) out of the returned word and extend.
  always_comb begin
    shifted = mem_rdata_i >> {off_q, 3'b000};
    ext     = mem_rdata_i;
    unique case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext = {24'h0, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ext = {16'h0, shifted[15:0]};
      default: ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      ldata_q     <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_i || store_i) begin
            if (req_err) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StResp;
            end else begin
              err_q       <= 1'b0;
              off_q       <= off;
              f3_q        <= funct3_i;
              mem_req_q   <= 1'b1;
              mem_we_q    <= ~load_i;
              mem_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              state_q     <= StReq;
            end
          end
        end
        StReq: begin
          // rvalid is deliberately ignored until the request has been granted
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              done_q  <= 1'b1;
              state_q <= StResp;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (mem_rvalid_i) begin
            ldata_q <= ext;
            done_q  <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o     = ((state_q == StIdle) && (load_i || store_i)) ||
                       (state_q == StReq) || (state_q == StWait);
  assign done_o      = done_q;
  assign misalign_o  = done_q & err_q;
  assign ldata_o     = ldata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load, store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign;
  logic [31:0] ldata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_ld = 32'h0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load), .store_i(store), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .done_o(done), .misalign_o(misalign),
    .ldata_o(ldata), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  // Reference model: plain arithmetic on the access rules.
  function automatic bit model_err(bit ld, logic [2:0] f3, logic [1:0] o);
    int size = int'(f3) % 4;
    bit legal;
    if (ld) legal = (f3 != 3) && (f3 != 6) && (f3 != 7);
    else    legal = (f3 <= 2);
    if (!legal) return 1'b1;
    return (int'(o) % (1 << size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(logic [2:0] f3, logic [1:0] o);
    int n = 1 << (int'(f3) % 4);
    int v = ((1 << n) - 1) << int'(o);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] wd);
    int size = int'(f3) % 4;
    if (size == 0) return {24'h0, wd[7:0]} * 32'h0101_0101;
    if (size == 1) return {16'h0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_ldata(logic [2:0] f3, logic [1:0] o, logic [31:0] rd);
    int size = int'(f3) % 4;
    bit sgn = (f3 < 4);
    logic [31:0] v = rd / (32'd1 << (8 * int'(o)));
    if (size == 0) begin
      v = v % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One access from the IDLE cycle (c=0) to its retire cycle, checked every cycle.
  // gd: gnt wait cycles; rdw: extra WAIT cycles before rvalid; noise: rvalid while in REQ.
  task automatic run_access(input string name, input bit ld, input bit st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                            input int gd, input int rdw, input bit noise);
    bit          is_ld = ld;
    bit          err   = model_err(is_ld, f3, a[1:0]);
    int          gnt_c = 1 + gd;
    int          rv_c  = gnt_c + 1 + rdw;
    int          done_c;
    bit          exp_req;
    logic [31:0] exp_addr = {a[31:2], 2'b00};
    if (err)        done_c = 1;
    else if (is_ld) done_c = rv_c + 1;
    else            done_c = gnt_c + 1;
    if (is_ld && !err) exp_ld = model_ldata(f3, a[1:0], rd);
    @(posedge clk); #1;
    load = ld; store = st; funct3 = f3; addr = a; wdata = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int c = 0; c <= done_c; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == done_c) begin load = 1'b0; store = 1'b0; end
      #1;
      exp_req = !err && c >= 1 && c <= gnt_c;
      checks++;
      if (stall !== (c < done_c)) begin
        failures++;
        $display("FAIL %s stall c=%0d got=%b exp=%b", name, c, stall, c < done_c);
      end
      checks++;
      if (done !== (c == done_c)) begin
        failures++;
        $display("FAIL %s done c=%0d got=%b exp=%b", name, c, done, c == done_c);
      end
      checks++;
      if (mem_req !== exp_req) begin
        failures++;
        $display("FAIL %s mem_req c=%0d got=%b exp=%b", name, c, mem_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        if (mem_addr !== exp_addr || mem_be !== model_be(f3, a[1:0]) || mem_we !== !is_ld ||
            (!is_ld && mem_wdata !== model_wdata(f3, wd))) begin
          failures++;
          $display("FAIL %s bus c=%0d got=%h/%b/%b/%h exp=%h/%b/%b/%h", name, c, mem_addr,
                   mem_be, mem_we, mem_wdata, exp_addr, model_be(f3, a[1:0]), !is_ld,
                   model_wdata(f3, wd));
        end
      end
      if (c == done_c) begin
        checks++;
        if (misalign !== err) begin
          failures++;
          $display("FAIL %s misalign got=%b exp=%b", name, misalign, err);
        end
        checks++;
        if (ldata !== exp_ld) begin
          failures++;
          $display("FAIL %s ldata got=%h exp=%h", name, ldata, exp_ld);
        end
      end
      mem_gnt    = (c == gnt_c) && !err;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (noise && c >= 1 && c < gnt_c) mem_rvalid = 1'b1;
      if (is_ld && !err && c == rv_c) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
      end
      if (c == done_c) begin mem_gnt = 1'b0; mem_rvalid = 1'b0; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({stall, done, misalign, mem_req, mem_we} !== 5'b0 || ldata !== 32'h0 ||
        mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset got=%b%b%b%b%b ld=%h a=%h be=%b wd=%h exp=all-zero", stall, done,
               misalign, mem_req, mem_we, ldata, mem_addr, mem_be, mem_wdata);
    end
    exp_ld = 32'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    run_access("sw",  1'b0, 1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
    run_access("sb",  1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, 1'b0);
    run_access("sh",  1'b0, 1'b1, 3'b001, 32'h212, 32'h1234_5678, 32'h0, 1, 0, 1'b0);
  endtask

  task automatic test_load_ext();
    run_access("lh",  1'b1, 1'b0, 3'b001, 32'h402, 32'h0, 32'h80F0_7F12, 0, 0, 1'b0);
    run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h402, 32'h0, 32'h80F0_7F12, 0, 0, 1'b0);
    run_access("lb",  1'b1, 1'b0, 3'b000, 32'h401, 32'h0, 32'h80F0_7F12, 0, 0, 1'b0);
    run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h403, 32'h0, 32'h80F0_7F12, 0, 0, 1'b0);
    run_access("lw",  1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h80F0_7F12, 0, 0, 1'b0);
  endtask

  task automatic test_misalign();
    run_access("lw_mis",  1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 1'b0);
    run_access("sh_mis",  1'b0, 1'b1, 3'b001, 32'h101, 32'hFFFF, 32'h0, 0, 0, 1'b0);
    run_access("ld_ill",  1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0);
    run_access("st_ill",  1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0);
    run_access("both_ld", 1'b1, 1'b1, 3'b100, 32'h101, 32'h0, 32'h0000_C300, 0, 0, 1'b0);
  endtask

  task automatic test_delayed();
    run_access("ld_slow", 1'b1, 1'b0, 3'b001, 32'h8000_0006, 32'h0, 32'hC0DE_1234, 3, 1, 1'b1);
    run_access("st_slow", 1'b0, 1'b1, 3'b000, 32'h8000_0005, 32'h77, 32'h0, 2, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    load = 1'b1; funct3 = 3'b010; addr = 32'h200;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst_n = 1'b0; load = 1'b0;
    @(posedge clk); #2;
    checks++;
    if ({stall, done, misalign, mem_req, mem_we} !== 5'b0 || ldata !== 32'h0 ||
        mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid outputs got=%b%b%b%b%b ld=%h a=%h exp=all-zero", stall, done,
               misalign, mem_req, mem_we, ldata, mem_addr);
    end
    exp_ld = 32'h0;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #2;
    mem_rvalid = 1'b0;
    checks++;
    if (ldata !== 32'h0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid late_rvalid ldata=%h done=%b exp=00000000/0", ldata, done);
    end
    run_access("after_rst", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h5A5A_0F0F, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int          mode = int'($urandom_range(0, 2));
      logic [2:0]  f3   = 3'($urandom_range(0, 7));
      logic [31:0] a    = $urandom;
      run_access("rand", mode != 1, mode != 0, f3, a, $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_ext();
    test_misalign();
    test_delayed();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
